ret_stack: RTL

Parametrised hardware return-address stack: the successor to the processor's single-word, memory-resident stack exchange used by the stack-jump instruction. It holds up to DEPTH entries of DATA_W bits in a circular buffer and supports push, pop and atomic exchange (pop-and-push in one cycle) for call/return sequences. Full and empty conditions are handled according to a mode parameter, and sticky overflow/underflow status flags are kept for the control unit. It sits beside the register file and feeds the PC-select mux in place of the old stack-value path.

---
 rtl/ret_stack.sv | 107 ++++++++++
 1 files changed

// File: rtl/ret_stack.sv
// Hardware return-address stack: circular buffer with push, pop and exchange,
// configurable full-stack policy and sticky overflow/underflow flags.
module ret_stack #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WRAP_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       flush,
  input  logic                       clr_flags,
  output logic [DATA_W-1:0]          top_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   sp_q, sp_d, top_idx, waddr;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              we;

  assign top_idx  = sp_q - PtrOne;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CntMax);
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign top_data = empty ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    // Clear first so any setting event below takes precedence.
    ovf_d   = clr_flags ? 1'b0 : ovf_q;
    unf_d   = clr_flags ? 1'b0 : unf_q;
    we      = 1'b0;
    waddr   = sp_q;
    if (flush) begin
      sp_d    = '0;
      count_d = '0;
    end else if (push && pop) begin
      we = 1'b1;
      if (empty) begin
        sp_d    = sp_q + PtrOne;
        count_d = CntOne;
        unf_d   = 1'b1;
      end else begin
        waddr = top_idx;
      end
    end else if (push) begin
      if (!full) begin
        we      = 1'b1;
        sp_d    = sp_q + PtrOne;
        count_d = count_q + CntOne;
      end else begin
        ovf_d = 1'b1;
        if (WRAP_MODE != 0) begin
          // Overwrite the oldest slot; count stays saturated.
          we   = 1'b1;
          sp_d = sp_q + PtrOne;
        end
      end
    end else if (pop) begin
      if (!empty) begin
        sp_d    = sp_q - PtrOne;
        count_d = count_q - CntOne;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage has no reset; gating with rst_n drops writes while reset is held.
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      mem_q[waddr] <= push_data;
    end
  end

endmodule
